// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-ported data memory
// among NUM_REQ requesters. It handles one access at a time: the access is
// issued, the arbiter waits MEM_LATENCY cycles, then completes to the owner.
// Optional feature macro: DMEM_ARB_FAST_WRITE_EN. When it is defined, a store
// finishes in ISSUE, and req_ready is its only completion indication.
module dmem_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic                             busy
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   last_q;      // most recent owner; the search starts just after it
  logic [OW-1:0]   owner_q;
  logic [CW-1:0]   cnt_q;
  logic [OW-1:0]   grant_idx, cand;
  logic            grant_found;

  // Round-robin pick: first set req_valid bit starting at last_q+1, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_q;
    cand        = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (grant_found) state_d = ISSUE;
`ifdef DMEM_ARB_FAST_WRITE_EN
      ISSUE: state_d = mem_we ? IDLE : WAIT;
`else
      ISSUE: state_d = WAIT;
`endif
      WAIT:  if (cnt_q == '0) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs. The one-cycle pulses are cleared every
  // cycle and set only for the owner. mem_* payload holds between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= OW'(NUM_REQ - 1);
      owner_q   <= '0;
      cnt_q     <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      mem_en    <= 1'b0;
      busy      <= (state_d != IDLE);
      if (state_q == IDLE && grant_found) begin
        owner_q              <= grant_idx;
        last_q               <= grant_idx;
        mem_we               <= req_write[grant_idx];
        mem_addr             <= req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata            <= req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        mem_en               <= 1'b1;
        req_ready[grant_idx] <= 1'b1;
      end
      if (state_q == ISSUE)
        cnt_q <= CW'(MEM_LATENCY - 1);
      else if (state_q == WAIT && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
      if (state_q == WAIT && cnt_q == '0) begin
        rsp_rdata          <= mem_we ? '0 : mem_rdata;
        rsp_valid[owner_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grants, memory
// accesses and responses (with their cycle numbers); a negedge monitor pops
// and compares them whenever the DUT pulses req_ready, mem_en or rsp_valid.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FAST_WRITE_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam int NR = 4, AW = 8, DW = 16, ML = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]    rsp_rdata, mem_wdata, mem_rdata;
  logic             mem_en, mem_we, busy;
  logic [AW-1:0]    mem_addr;

  dmem_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(ML)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory model: unwritten words read as init_val(addr); read data appears
  // ML cycles after mem_en.
  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h05) ? 16'h1234 : {8'hC0, a};
  endfunction

  bit [15:0] wmem [256];
  bit        written [256];
  bit [15:0] rd_pipe [ML];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    rd_pipe[0] <= !mem_en ? 16'h0 : (written[mem_addr] ? wmem[mem_addr] : init_val(mem_addr));
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[ML-1];

  // Scoreboard
  typedef struct { int idx; bit we; logic [7:0] addr; logic [15:0] data; int cyc; } exp_t;
  exp_t q_rdy[$], q_mem[$], q_rsp[$];
  int n_chk = 0, n_pass = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic void unexpected(input string name);
    n_chk++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endfunction

  task automatic expect_txn(input int idx, input bit we, input logic [7:0] a,
                            input logic [15:0] wd, input logic [15:0] rd,
                            input int g, input bit has_rsp);
    exp_t e;
    e.idx = idx; e.we = we; e.addr = a; e.data = wd; e.cyc = g;
    q_rdy.push_back(e);
    q_mem.push_back(e);
    if (has_rsp) begin
      e.data = rd; e.cyc = g + ML + 1;
      q_rsp.push_back(e);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (req_ready != '0) begin
        if (q_rdy.size() == 0) unexpected("req_ready");
        else begin
          e = q_rdy.pop_front();
          chk("ready_vec", 32'(req_ready), 32'(1 << e.idx));
          chk("ready_cyc", cyc, e.cyc);
        end
      end
      if (mem_en) begin
        if (q_mem.size() == 0) unexpected("mem_en");
        else begin
          e = q_mem.pop_front();
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
        end
      end
      if (rsp_valid != '0) begin
        if (q_rsp.size() == 0) unexpected("rsp_valid");
        else begin
          e = q_rsp.pop_front();
          chk("rsp_vec", 32'(rsp_valid), 32'(1 << e.idx));
          chk("rsp_cyc", cyc, e.cyc);
          chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        end
      end
    end
  end

  // Stimulus helpers
  task automatic at_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input int idx, input bit we, input logic [7:0] a, input logic [15:0] d);
    req_valid[idx] = 1'b1;
    req_write[idx] = we;
    req_addr[idx*AW +: AW] = a;
    req_wdata[idx*DW +: DW] = d;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_rsp"}, 32'(rsp_valid), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int g, p, r;
    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Round robin: all four hold loads; order 0,1,2,3,0,1 five cycles apart
    @(posedge clk); #1;
    g = cyc + 1;
    for (int i = 0; i < 6; i++)
      expect_txn(i % NR, 1'b0, 8'h30 + 8'(i % NR), 16'h0, init_val(8'h30 + 8'(i % NR)), g + 5*i, 1'b1);
    for (int i = 0; i < NR; i++) drive(i, 1'b0, 8'h30 + 8'(i), 16'h0);
    at_cyc(g + 25);
    req_valid = '0;
    at_cyc(g + 30);

    // Single load: requester 2, addr 0x05 -> 0x1234; busy falls in cycle 5
    @(posedge clk); #1;
    g = cyc + 1;
    expect_txn(2, 1'b0, 8'h05, 16'h0, 16'h1234, g, 1'b1);
    drive(2, 1'b0, 8'h05, 16'h0);
    at_cyc(g); req_valid[2] = 1'b0;
    at_cyc(g + 3); @(negedge clk);
    chk("busy_in_resp", 32'(busy), 1);
    at_cyc(g + 4); @(negedge clk);
    chk("busy_fall", 32'(busy), 0);

    // Store 0xBEEF to 0x0A from requester 1, then load it back
    @(posedge clk); #1;
    g = cyc + 1;
    expect_txn(1, 1'b1, 8'h0A, 16'hBEEF, 16'h0, g, !FAST);
    drive(1, 1'b1, 8'h0A, 16'hBEEF);
    at_cyc(g); req_valid[1] = 1'b0;
    at_cyc(g + 6);
    @(posedge clk); #1;
    g = cyc + 1;
    expect_txn(1, 1'b0, 8'h0A, 16'h0, 16'hBEEF, g, 1'b1);
    drive(1, 1'b0, 8'h0A, 16'h0);
    at_cyc(g); req_valid[1] = 1'b0;
    at_cyc(g + 6);

    // Late request: requester 0 raises valid during RESP of requester 1
    @(posedge clk); #1;
    g = cyc + 1;
    expect_txn(1, 1'b0, 8'h10, 16'h0, init_val(8'h10), g, 1'b1);
    expect_txn(0, 1'b0, 8'h11, 16'h0, init_val(8'h11), g + 5, 1'b1);
    drive(1, 1'b0, 8'h10, 16'h0);
    at_cyc(g); req_valid[1] = 1'b0;
    at_cyc(g + 3);
    drive(0, 1'b0, 8'h11, 16'h0);
    at_cyc(g + 5); req_valid[0] = 1'b0;
    at_cyc(g + 11);

    // Back-to-back stores from requester 3
    p = FAST ? 2 : 5;
    @(posedge clk); #1;
    g = cyc + 1;
    for (int k = 0; k < 3; k++)
      expect_txn(3, 1'b1, 8'h20 + 8'(k), 16'hA000 + 16'(k), 16'h0, g + k*p, !FAST);
    drive(3, 1'b1, 8'h20, 16'hA000);
    for (int k = 0; k < 3; k++) begin
      at_cyc(g + k*p);
      if (k < 2) drive(3, 1'b1, 8'h20 + 8'(k+1), 16'hA000 + 16'(k+1));
      else       req_valid[3] = 1'b0;
    end
    at_cyc(g + 2*p + 6);
    @(posedge clk); #1;
    g = cyc + 1;
    expect_txn(3, 1'b0, 8'h22, 16'h0, 16'hA002, g, 1'b1);
    drive(3, 1'b0, 8'h22, 16'h0);
    at_cyc(g); req_valid[3] = 1'b0;
    at_cyc(g + 6);

    // Reset one cycle after mem_en: no response; then 0 wins over 3
    @(posedge clk); #1;
    g = cyc + 1;
    q_rdy.push_back('{2, 1'b0, 8'h50, 16'h0, g});
    q_mem.push_back('{2, 1'b0, 8'h50, 16'h0, g});
    drive(2, 1'b0, 8'h50, 16'h0);
    at_cyc(g); req_valid[2] = 1'b0;
    at_cyc(g + 1);
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    drive(0, 1'b0, 8'h40, 16'h0);
    drive(3, 1'b0, 8'h43, 16'h0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    r = cyc;
    expect_txn(0, 1'b0, 8'h40, 16'h0, init_val(8'h40), r + 1, 1'b1);
    expect_txn(3, 1'b0, 8'h43, 16'h0, init_val(8'h43), r + 6, 1'b1);
    at_cyc(r + 1); req_valid[0] = 1'b0;
    at_cyc(r + 6); req_valid[3] = 1'b0;
    at_cyc(r + 12);

    // Everything expected must have been seen
    chk("rdy_left", q_rdy.size(), 0);
    chk("mem_left", q_mem.size(), 0);
    chk("rsp_left", q_rsp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
